reg_bus_master: RTL

//  Bus initiator for the bank of 16-bit registers (regSixteen style: R_W load strobe, Ea output enable, Qa read bus).

---
 rtl/reg_bus_master_pkg.sv | 31 +++
 rtl/reg_bus_master_sel_decode.sv | 21 ++
 rtl/reg_bus_master.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/reg_bus_master_pkg.sv
// Opcode and FSM state encodings shared by the register-bus initiator and its decoder.
// Small helpers classify which opcodes touch the read path and which touch the write path.
package reg_bus_master_pkg;

  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_MOVE  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ENABLE = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_SETUP  = 3'd3,
    ST_STROBE = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  function automatic logic op_reads(input op_e op);
    return (op == OP_READ) || (op == OP_MOVE);
  endfunction

  function automatic logic op_writes(input op_e op);
    return (op == OP_WRITE) || (op == OP_MOVE);
  endfunction

endpackage

// File: rtl/reg_bus_master_sel_decode.sv
// Register index to one-hot select, gated by an enable, with an out-of-range flag.
// Purely combinational; the flag is independent of the enable.
module reg_bus_master_sel_decode #(
  parameter int NREG  = 4,
  parameter int IDX_W = 2
) (
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [NREG-1:0]  onehot,
  output logic             oor
);

  always_comb begin
    onehot = '0;
    oor    = (32'(idx) >= 32'(NREG));
    for (int i = 0; i < NREG; i++) begin
      onehot[i] = en && (32'(idx) == 32'(i));
    end
  end

endmodule

// File: rtl/reg_bus_master.sv
// Register-bank bus initiator: sequences WRITE/READ/MOVE onto D/R_W/Ea/Qa, one command at a time.
// Latency after accept: WRITE/READ S+2, MOVE 2S+3, NOP/illegal 1; CmdReady only while idle.
module reg_bus_master
  import reg_bus_master_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int NREG       = 4,
  parameter int IDX_W      = 2,
  parameter int SETTLE_CYC = 1
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              CmdValid,
  output logic              CmdReady,
  input  logic [1:0]        CmdOp,
  input  logic [IDX_W-1:0]  CmdDst,
  input  logic [IDX_W-1:0]  CmdSrc,
  input  logic [DATA_W-1:0] CmdData,
  output logic [DATA_W-1:0] BusD,
  output logic [NREG-1:0]   BusRw,
  output logic [NREG-1:0]   BusEa,
  input  logic [DATA_W-1:0] BusQa,
  output logic              RspValid,
  output logic              RspErr,
  output logic [DATA_W-1:0] RspData
);

  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  op_e                op_q, op_d;
  logic [IDX_W-1:0]   dst_q, dst_d;
  logic [IDX_W-1:0]   src_q, src_d;
  logic [DATA_W-1:0]  hold_q, hold_d;
  logic [DATA_W-1:0]  bus_d_q, bus_d_d;
  logic               rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;

  op_e               cmd_op;
  logic              cmd_rdy;
  logic              accept;
  logic              cmd_illegal;
  logic              rw_en, ea_en;
  logic              rsp_vld, rsp_err;
  logic [IDX_W-1:0]  rw_idx, ea_idx;
  logic [NREG-1:0]   rw_onehot, ea_onehot;
  logic              dst_oor, src_oor;

  assign cmd_op = op_e'(CmdOp);
  assign accept = CmdValid && cmd_rdy;

  // While idle the decoders look at the incoming command so legality is known at accept.
  assign rw_idx = (state_q == ST_IDLE) ? CmdDst : dst_q;
  assign ea_idx = (state_q == ST_IDLE) ? CmdSrc : src_q;

  reg_bus_master_sel_decode #(
    .NREG  (NREG),
    .IDX_W (IDX_W)
  ) u_rw_dec (
    .idx    (rw_idx),
    .en     (rw_en),
    .onehot (rw_onehot),
    .oor    (dst_oor)
  );

  reg_bus_master_sel_decode #(
    .NREG  (NREG),
    .IDX_W (IDX_W)
  ) u_ea_dec (
    .idx    (ea_idx),
    .en     (ea_en),
    .onehot (ea_onehot),
    .oor    (src_oor)
  );

  assign cmd_illegal = (op_reads(cmd_op) && src_oor) || (op_writes(cmd_op) && dst_oor);

  always_ff @(posedge Clk) begin
    if (Clr) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      op_q       <= OP_NOP;
      dst_q      <= '0;
      src_q      <= '0;
      hold_q     <= '0;
      bus_d_q    <= '0;
      rsp_err_q  <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      dst_q      <= dst_d;
      src_q      <= src_d;
      hold_q     <= hold_d;
      bus_d_q    <= bus_d_d;
      rsp_err_q  <= rsp_err_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cnt_d = '0;
          if (cmd_illegal || (cmd_op == OP_NOP)) begin
            state_d = ST_DONE;
          end else if (cmd_op == OP_WRITE) begin
            state_d = ST_SETUP;
          end else begin
            state_d = ST_ENABLE;
          end
        end
      end
      ST_ENABLE: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SAMPLE: begin
        cnt_d   = '0;
        state_d = (op_q == OP_MOVE) ? ST_SETUP : ST_DONE;
      end
      ST_SETUP: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_STROBE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STROBE: state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // BusD only moves on the edge into SETUP, so it is stable from SETUP through STROBE.
  always_comb begin
    op_d       = op_q;
    dst_d      = dst_q;
    src_d      = src_q;
    hold_d     = hold_q;
    bus_d_d    = bus_d_q;
    rsp_err_d  = rsp_err_q;
    rsp_data_d = rsp_data_q;
    if (accept) begin
      op_d      = cmd_op;
      dst_d     = CmdDst;
      src_d     = CmdSrc;
      rsp_err_d = cmd_illegal;
    end
    case (state_q)
      ST_IDLE: begin
        if (accept && (cmd_op == OP_WRITE) && !cmd_illegal) begin
          bus_d_d = CmdData;
        end
      end
      ST_SAMPLE: begin
        hold_d = BusQa;
        if (op_q == OP_MOVE) begin
          bus_d_d = BusQa;
        end else begin
          rsp_data_d = BusQa;
        end
      end
      ST_STROBE: begin
        rsp_data_d = (op_q == OP_MOVE) ? hold_q : bus_d_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    cmd_rdy = (state_q == ST_IDLE) && !Clr;
    rw_en   = (state_q == ST_STROBE);
    ea_en   = (state_q == ST_ENABLE) || (state_q == ST_SAMPLE);
    rsp_vld = (state_q == ST_DONE);
    rsp_err = rsp_vld && rsp_err_q;
  end

  assign CmdReady = cmd_rdy;
  assign BusD     = bus_d_q;
  assign BusRw    = rw_onehot;
  assign BusEa    = ea_onehot;
  assign RspValid = rsp_vld;
  assign RspErr   = rsp_err;
  assign RspData  = rsp_data_q;

endmodule
